// File: rtl/puf_pkg.sv
// Shared definitions for the PUF challenge sequencer.
// Holds the sequencer state type, the LFSR challenge width and the default
// response width / settle length used as parameter defaults.
package puf_pkg;

  localparam int unsigned CHAL_W                = 8;
  localparam int unsigned RESP_W_DEFAULT        = 32;
  localparam int unsigned SETTLE_CYCLES_DEFAULT = 4;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StApply,
    StSettle,
    StSample,
    StStep,
    StOut
  } state_e;

endpackage

// File: rtl/puf_settle_timer.sv
// Settle-wait down-counter for the PUF challenge sequencer.
// Ports:
//   clk, reset - clock, asynchronous active-high reset
//   load       - (re)start the wait; asserted during the fire cycle
//   done       - high in the last cycle of the SETTLE_CYCLES-long wait
module puf_settle_timer
  import puf_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic done
);

  logic [7:0] count_q;

  // Loaded with SETTLE_CYCLES-1 so the final settle cycle sees count_q == 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 8'd0;
    end else if (load) begin
      count_q <= 8'(SETTLE_CYCLES - 1);
    end else if (count_q != 8'd0) begin
      count_q <= count_q - 8'd1;
    end
  end

  assign done = (count_q == 8'd0);

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Runs a sequence of LFSR-generated challenges through a PUF and collects one
// response bit per challenge into a word, first response ending up in the MSB
// of the valid field.
// Ports:
//   clk, reset             - clock, asynchronous active-high reset
//   start, abort           - run request (IDLE only), synchronous cancel
//   seed, num_chal         - first challenge, number of challenges requested
//   lfsr_seed/load/step    - control of the external LFSR
//   lfsr_chal              - current LFSR challenge
//   puf_chal, puf_fire     - registered challenge and launch pulse to the PUF
//   puf_resp               - PUF response bit
//   busy                   - high whenever not IDLE
//   resp_valid/ready       - response word handshake
//   resp_word, resp_count  - collected bits and number of valid bits
module puf_challenge_sequencer
  import puf_pkg::*;
#(
  parameter int unsigned CHAL_W        = puf_pkg::CHAL_W,
  parameter int unsigned RESP_W        = puf_pkg::RESP_W_DEFAULT,
  parameter int unsigned SETTLE_CYCLES = puf_pkg::SETTLE_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [CHAL_W-1:0] seed,
  input  logic [7:0]        num_chal,
  output logic [CHAL_W-1:0] lfsr_seed,
  output logic              lfsr_load,
  output logic              lfsr_step,
  input  logic [CHAL_W-1:0] lfsr_chal,
  output logic [CHAL_W-1:0] puf_chal,
  output logic              puf_fire,
  input  logic              puf_resp,
  output logic              busy,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [RESP_W-1:0] resp_word,
  output logic [7:0]        resp_count
);

  // Largest run length representable in the 8-bit count.
  localparam logic [7:0] NCap = (RESP_W > 255) ? 8'd255 : 8'(RESP_W);

  state_e            state_q, state_d;
  logic [CHAL_W-1:0] seed_q;
  logic [7:0]        n_q, idx_q, n_start;
  logic              accept, settle_done;

  assign n_start   = (num_chal > NCap) ? NCap : num_chal;
  assign accept    = (state_q == StIdle) && start && !abort;
  assign lfsr_seed = seed_q;

  puf_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk  (clk),
    .reset(reset),
    .load (state_q == StApply),
    .done (settle_done)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = (n_start == 8'd0) ? StOut : StLoad;
      StLoad:   state_d = StApply;
      StApply:  state_d = StSettle;
      StSettle: if (settle_done) state_d = StSample;
      StSample: state_d = (idx_q + 8'd1 == n_q) ? StOut : StStep;
      StStep:   state_d = StApply;
      StOut:    if (resp_valid && resp_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (abort) state_d = StIdle;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      seed_q     <= '0;
      n_q        <= 8'd0;
      idx_q      <= 8'd0;
      puf_chal   <= '0;
      busy       <= 1'b0;
      lfsr_load  <= 1'b0;
      lfsr_step  <= 1'b0;
      puf_fire   <= 1'b0;
      resp_valid <= 1'b0;
      resp_word  <= '0;
      resp_count <= 8'd0;
    end else begin
      state_q   <= state_d;
      // Outputs decoded from the next state so they align with the state.
      busy      <= (state_d != StIdle);
      lfsr_load <= (state_d == StLoad);
      lfsr_step <= (state_d == StStep);
      puf_fire  <= (state_d == StApply);
      // Valid rises on the second OUT cycle, once the final bit is in the word.
      resp_valid <= (state_q == StOut) && (state_d == StOut);
      if (accept) begin
        seed_q     <= seed;
        n_q        <= n_start;
        idx_q      <= 8'd0;
        resp_word  <= '0;
        resp_count <= 8'd0;
      end
      // The LFSR updates on the edge entering APPLY, so capture as APPLY ends.
      if (state_q == StApply && !abort) begin
        puf_chal <= lfsr_chal;
      end
      if (state_q == StSample && !abort) begin
        resp_word <= {resp_word[RESP_W-2:0], puf_resp};
        idx_q     <= idx_q + 8'd1;
      end
      if (state_q == StOut && state_d == StOut) begin
        resp_count <= idx_q;
      end
    end
  end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
module tb_puf_challenge_sequencer;
  import puf_pkg::*;

  localparam int unsigned RespW  = RESP_W_DEFAULT;
  localparam int unsigned Settle = SETTLE_CYCLES_DEFAULT;

  logic             clk = 1'b0;
  logic             reset = 1'b1, start = 1'b0, abort = 1'b0, resp_ready = 1'b0;
  logic [7:0]       seed = 8'd0, num_chal = 8'd0;
  logic [7:0]       lfsr_seed, lfsr_chal, puf_chal, resp_count;
  logic             lfsr_load, lfsr_step, puf_fire, puf_resp, busy, resp_valid;
  logic [RespW-1:0] resp_word;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = 0;

  // Observations gathered on the falling edge.
  int         fire_cnt = 0, load_cnt = 0, step_cnt = 0, overlap_cnt = 0, valid_rise_cnt = 0;
  logic       fire_prev = 1'b0, valid_prev = 1'b0;
  logic [7:0] last_load_seed = 8'd0;
  logic [7:0] obs_chal_q[$];

  // Scoreboard of expected results, filled when a run is started.
  logic [7:0]       exp_chal_q[$];
  logic [RespW-1:0] exp_word_q[$];
  int               exp_count_q[$];
  int               exp_lat_q[$];

  puf_challenge_sequencer #(
    .CHAL_W(8),
    .RESP_W(RespW),
    .SETTLE_CYCLES(Settle)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .seed      (seed),
    .num_chal  (num_chal),
    .lfsr_seed (lfsr_seed),
    .lfsr_load (lfsr_load),
    .lfsr_step (lfsr_step),
    .lfsr_chal (lfsr_chal),
    .puf_chal  (puf_chal),
    .puf_fire  (puf_fire),
    .puf_resp  (puf_resp),
    .busy      (busy),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_word (resp_word),
    .resp_count(resp_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // 8-bit Fibonacci LFSR, taps x^8 + x^6 + x^5 + x^4 + 1.
  function automatic logic [7:0] lfsr_next(input logic [7:0] c);
    return {c[6:0], c[7] ^ c[5] ^ c[4] ^ c[3]};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) lfsr_chal <= 8'd0;
    else if (lfsr_load) lfsr_chal <= lfsr_seed;
    else if (lfsr_step) lfsr_chal <= lfsr_next(lfsr_chal);
  end

  assign puf_resp = ^puf_chal;

  always @(negedge clk) begin
    if (fire_prev) obs_chal_q.push_back(puf_chal);
    fire_prev = puf_fire;
    if (puf_fire) fire_cnt++;
    if (lfsr_load) begin
      load_cnt++;
      last_load_seed = lfsr_seed;
    end
    if (lfsr_step) step_cnt++;
    if (int'(puf_fire) + int'(lfsr_load) + int'(lfsr_step) > 1) overlap_cnt++;
    if (resp_valid && !valid_prev) valid_rise_cnt++;
    valid_prev = resp_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_chal_q.delete();
    fire_cnt = 0; load_cnt = 0; step_cnt = 0; overlap_cnt = 0; valid_rise_cnt = 0;
  endtask

  task automatic flush_exp();
    exp_chal_q.delete(); exp_word_q.delete(); exp_count_q.delete(); exp_lat_q.delete();
  endtask

  task automatic run_start(input logic [7:0] s, input logic [7:0] num);
    logic [7:0]       c;
    logic [RespW-1:0] w;
    int               n;
    n = (int'(num) > int'(RespW)) ? int'(RespW) : int'(num);
    c = s;
    w = '0;
    for (int i = 0; i < n; i++) begin
      exp_chal_q.push_back(c);
      w = {w[RespW-2:0], ^c};
      c = lfsr_next(c);
    end
    exp_word_q.push_back(w);
    exp_count_q.push_back(n);
    exp_lat_q.push_back(n * (int'(Settle) + 3) + 1);
    seed = s;
    num_chal = num;
    start = 1'b1;
    tick();
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok, output int lat);
    ok = 1'b0;
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      if (resp_valid) begin
        ok = 1'b1;
        lat = cyc - start_cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({busy, resp_valid, lfsr_load, lfsr_step, puf_fire} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 00000",
               {busy, resp_valid, lfsr_load, lfsr_step, puf_fire});
    end
    n_cmp++;
    if (puf_chal !== 8'd0) begin n_err++; $display("FAIL reset_puf_chal: got %h want 00", puf_chal); end
    n_cmp++;
    if (lfsr_seed !== 8'd0) begin n_err++; $display("FAIL reset_lfsr_seed: got %h want 00", lfsr_seed); end
    n_cmp++;
    if (resp_word !== '0) begin n_err++; $display("FAIL reset_resp_word: got %h want 0", resp_word); end
    n_cmp++;
    if (resp_count !== 8'd0) begin n_err++; $display("FAIL reset_resp_count: got %0d want 0", resp_count); end
    reset = 1'b0;
    tick();
  endtask

  // Full run: latency, pulse counts, challenge order, word and count, handshake.
  task automatic test_run(input string name, input logic [7:0] s, input logic [7:0] num);
    bit               ok;
    int               lat, exp_lat, exp_cnt, n_exp;
    logic [7:0]       ec, oc;
    logic [RespW-1:0] ew;
    clear_obs();
    run_start(s, num);
    wait_valid(600, ok, lat);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL %s_valid_timeout: got no resp_valid want resp_valid", name); end
    exp_lat = exp_lat_q.pop_front();
    ew      = exp_word_q.pop_front();
    exp_cnt = exp_count_q.pop_front();
    n_exp   = exp_chal_q.size();
    n_cmp++;
    if (lat != exp_lat) begin n_err++; $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat); end
    n_cmp++;
    if (fire_cnt != n_exp) begin n_err++; $display("FAIL %s_fires: got %0d want %0d", name, fire_cnt, n_exp); end
    n_cmp++;
    if (load_cnt != ((n_exp > 0) ? 1 : 0)) begin
      n_err++; $display("FAIL %s_loads: got %0d want %0d", name, load_cnt, (n_exp > 0) ? 1 : 0);
    end
    n_cmp++;
    if (step_cnt != ((n_exp > 0) ? n_exp - 1 : 0)) begin
      n_err++; $display("FAIL %s_steps: got %0d want %0d", name, step_cnt, (n_exp > 0) ? n_exp - 1 : 0);
    end
    n_cmp++;
    if (overlap_cnt != 0) begin n_err++; $display("FAIL %s_pulse_overlap: got %0d want 0", name, overlap_cnt); end
    for (int i = 0; i < n_exp; i++) begin
      ec = exp_chal_q.pop_front();
      oc = (obs_chal_q.size() > 0) ? obs_chal_q.pop_front() : 8'hxx;
      n_cmp++;
      if (oc !== ec) begin n_err++; $display("FAIL %s_chal%0d: got %h want %h", name, i, oc, ec); end
    end
    n_cmp++;
    if (resp_word !== ew) begin n_err++; $display("FAIL %s_word: got %h want %h", name, resp_word, ew); end
    n_cmp++;
    if (int'(resp_count) != exp_cnt) begin
      n_err++; $display("FAIL %s_count: got %0d want %0d", name, resp_count, exp_cnt);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    n_cmp++;
    if ({busy, resp_valid} !== 2'b00) begin
      n_err++; $display("FAIL %s_to_idle: got busy/valid %b want 00", name, {busy, resp_valid});
    end
  endtask

  task automatic test_hold();
    bit               ok;
    int               lat, ec;
    logic [RespW-1:0] ew;
    clear_obs();
    run_start(8'h3C, 8'd5);
    wait_valid(200, ok, lat);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL hold_valid_timeout: got no resp_valid want resp_valid"); end
    ew = exp_word_q.pop_front();
    ec = exp_count_q.pop_front();
    flush_exp();
    for (int i = 0; i < 10; i++) begin
      start = (i % 3 == 0);
      seed = 8'hFF;
      num_chal = 8'd2;
      tick();
      n_cmp++;
      if ({resp_valid, resp_count, resp_word} !== {1'b1, 8'(ec), ew}) begin
        n_err++;
        $display("FAIL hold_stable%0d: got v=%b n=%0d w=%h want v=1 n=%0d w=%h",
                 i, resp_valid, resp_count, resp_word, ec, ew);
      end
    end
    start = 1'b0;
    n_cmp++;
    if (load_cnt != 1) begin n_err++; $display("FAIL hold_start_ignored: got %0d loads want 1", load_cnt); end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    n_cmp++;
    if ({busy, resp_valid} !== 2'b00) begin
      n_err++; $display("FAIL hold_to_idle: got busy/valid %b want 00", {busy, resp_valid});
    end
    tick();
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL hold_stay_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_abort();
    int n;
    clear_obs();
    run_start(8'h11, 8'd4);
    for (n = 0; n < 100 && fire_cnt < 2; n++) tick();
    // Now in the first cycle of the second settle wait.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    flush_exp();
    n_cmp++;
    if ({busy, resp_valid} !== 2'b00) begin
      n_err++; $display("FAIL abort_idle: got busy/valid %b want 00", {busy, resp_valid});
    end
    repeat (60) tick();
    n_cmp++;
    if (valid_rise_cnt != 0 || fire_cnt != 2 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_quiet: got rises=%0d fires=%0d busy=%b want 0/2/0",
               valid_rise_cnt, fire_cnt, busy);
    end
    clear_obs();
    run_start(8'd68, 8'd1);
    tick();
    n_cmp++;
    if (last_load_seed !== 8'd68) begin
      n_err++; $display("FAIL abort_reseed: got %0d want 68", last_load_seed);
    end
    flush_exp();
    repeat (20) tick();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n, fires;
    clear_obs();
    run_start(8'h09, 8'd4);
    for (n = 0; n < 100 && lfsr_step !== 1'b1; n++) tick();
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({busy, resp_valid, lfsr_step, puf_chal} !== 11'b0) begin
      n_err++;
      $display("FAIL rstmid_clear: got busy=%b v=%b step=%b chal=%h want all 0",
               busy, resp_valid, lfsr_step, puf_chal);
    end
    tick();
    reset = 1'b0;
    flush_exp();
    fires = fire_cnt;
    repeat (30) tick();
    n_cmp++;
    if (fire_cnt != fires || busy !== 1'b0 || valid_rise_cnt != 0) begin
      n_err++;
      $display("FAIL rstmid_quiet: got fires=%0d busy=%b rises=%0d want %0d/0/0",
               fire_cnt, busy, valid_rise_cnt, fires);
    end
    test_run("after_reset", 8'd68, 8'd2);
    n_cmp++;
    if (last_load_seed !== 8'd68) begin
      n_err++; $display("FAIL rstmid_reseed: got %0d want 68", last_load_seed);
    end
  endtask

  initial begin
    test_reset();
    test_run("basic", 8'd2, 8'd3);
    test_run("zero", 8'h5A, 8'd0);
    test_run("saturate", 8'h81, 8'd40);
    test_run("mixed", 8'hC7, 8'd9);
    test_hold();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
